// File: rtl/branch_seq_pkg.sv
// branch_seq_pkg: shared FSM states, opcodes, funct3 codes and the branch compare helper.
package branch_seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, WAIT_OPS, UPDATE} state_e;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  // funct3 010/011 are reserved and resolve as not taken
  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      F3_BEQ:  return a == b;
      F3_BNE:  return a != b;
      F3_BLT:  return $signed(a) < $signed(b);
      F3_BGE:  return $signed(a) >= $signed(b);
      F3_BLTU: return a < b;
      F3_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/branch_seq_imm_dec.sv
// branch_imm_dec: sign-extended B-type or J-type immediate from the instruction body.
module branch_imm_dec (
  input  logic [31:7] instr,
  input  logic        is_jal,
  output logic [31:0] imm
);
  always_comb
    imm = is_jal ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
                 : {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
endmodule

// File: rtl/branch_seq.sv
// branch_seq: fetch/decode/branch-resolve sequencer driving a simple instruction port.
// Define BRANCH_SEQ_JAL_EN to redirect on JAL; otherwise JAL falls through to pc+4.
module branch_seq
  import branch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        ops_valid,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic [31:0] pc,
  output logic        branch_taken,
  output logic        misalign_err,
  output logic        busy
);
  state_e      state_q;
  logic [31:0] pc_q, next_pc_q, instr_q, imm, target, next_pc_d;
  logic        imem_req_q, instr_valid_q, branch_taken_q, misalign_err_q;
  logic        is_br, is_jal, redirect, misalign;
`ifdef BRANCH_SEQ_JAL_EN
  assign is_jal = instr_q[6:0] == OPC_JAL;
`else
  assign is_jal = 1'b0;
`endif
  branch_imm_dec u_imm_dec (
    .instr  (instr_q[31:7]),
    .is_jal (is_jal),
    .imm    (imm)
  );
  assign is_br     = instr_q[6:0] == OPC_BRANCH;
  assign target    = pc_q + imm;
  assign redirect  = is_jal | (is_br & br_taken(instr_q[14:12], rs1_val, rs2_val));
  assign misalign  = redirect & target[1];
  assign next_pc_d = redirect ? target : pc_q + 32'd4;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      next_pc_q      <= RESET_PC;
      instr_q        <= '0;
      imem_req_q     <= 1'b0;
      instr_valid_q  <= 1'b0;
      branch_taken_q <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      instr_valid_q  <= 1'b0;
      branch_taken_q <= 1'b0;
      misalign_err_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q    <= FETCH;
          imem_req_q <= 1'b1;
        end
        FETCH: if (imem_gnt) begin
          instr_q       <= imem_rdata;
          instr_valid_q <= 1'b1;
          imem_req_q    <= 1'b0;
          state_q       <= DECODE;
        end
        DECODE: if (is_br) begin
          state_q <= WAIT_OPS;
        end else if (misalign) begin
          misalign_err_q <= 1'b1;
          state_q        <= IDLE;
        end else begin
          next_pc_q      <= next_pc_d;
          branch_taken_q <= redirect;
          state_q        <= UPDATE;
        end
        WAIT_OPS: if (ops_valid) begin
          if (misalign) begin
            misalign_err_q <= 1'b1;
            state_q        <= IDLE;
          end else begin
            next_pc_q      <= next_pc_d;
            branch_taken_q <= redirect;
            state_q        <= UPDATE;
          end
        end
        UPDATE: begin
          pc_q       <= next_pc_q;
          imem_req_q <= run;
          state_q    <= run ? FETCH : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign imem_req     = imem_req_q;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign instr_out    = instr_q;
  assign instr_valid  = instr_valid_q;
  assign branch_taken = branch_taken_q;
  assign misalign_err = misalign_err_q;
  assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_branch_seq.sv
// tb_branch_seq: directed vectors for branch_seq with hand-computed pc/pulse expectations.
module tb_branch_seq;
  logic        clk = 1'b0;
  logic        rst_n, start, run, imem_gnt, ops_valid;
  logic [31:0] imem_rdata, rs1_val, rs2_val;
  logic        imem_req, instr_valid, branch_taken, misalign_err, busy;
  logic [31:0] imem_addr, instr_out, pc;
  int          n_chk = 0, n_pass = 0;
  int          cyc;
  logic        bt, me;
  logic [31:0] jal_pc;

  branch_seq dut (
    .clk, .rst_n, .start, .run, .imem_req, .imem_addr, .imem_gnt, .imem_rdata,
    .instr_out, .instr_valid, .ops_valid, .rs1_val, .rs2_val, .pc,
    .branch_taken, .misalign_err, .busy
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h exp %h", tag, got, exp);
  endtask

  function automatic logic [31:0] btype(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_req", {31'd0, imem_req}, 1);
  endtask

  task automatic exec(input logic [31:0] ins, input int hold, output int c, output logic t, output logic m);
    logic done;
    t = 1'b0; m = 1'b0; c = 0; done = 1'b0;
    imem_gnt = 1'b1; imem_rdata = ins; ops_valid = (hold == 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        imem_gnt = 1'b0;
        check("ivalid", {31'd0, instr_valid}, 1);
        check("iout", instr_out, ins);
      end
      if (hold > 0 && i == 1) start = 1'b1;
      if (hold > 0 && i == 2) start = 1'b0;
      if (hold > 1 && i == hold - 1) check("hold_wait", {30'd0, busy, imem_req}, 2);
      if (i == hold) ops_valid = 1'b1;
      t |= branch_taken; m |= misalign_err; c = i + 1;
      if (imem_req || !busy) begin done = 1'b1; break; end
    end
    check("exec_done", {31'd0, done}, 1);
  endtask

  task automatic br(input string tag, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp_pc, input logic exp_bt);
    rs1_val = a; rs2_val = b;
    exec(ins, 0, cyc, bt, me);
    check({tag, "_pc"}, imem_addr, exp_pc);
    check({tag, "_bt"}, {31'd0, bt}, {31'd0, exp_bt});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; run = 1'b1; imem_gnt = 1'b0; ops_valid = 1'b1;
    imem_rdata = '0; rs1_val = '0; rs2_val = '0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_out", {imem_req, instr_valid, branch_taken, misalign_err, busy}, 0);
    check("rst_instr", instr_out, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    go();
    check("fetch_addr", imem_addr, 32'h0);
    exec(32'h0000_0013, 0, cyc, bt, me);
    check("addi_lat", cyc, 3);
    check("addi_addr", imem_addr, 32'h4);
    br("to100", btype(3'b000, 13'h0FC), 32'd0, 32'd0, 32'h100, 1'b1);
    br("beq", btype(3'b000, 13'h010), 32'd5, 32'd5, 32'h110, 1'b1);
    br("bne", btype(3'b001, 13'h1FF0), 32'd1, 32'd2, 32'h100, 1'b1);
    br("blt", btype(3'b100, 13'h1FF8), 32'hFFFF_FFFF, 32'd1, 32'hF8, 1'b1);
    br("bgeu", btype(3'b111, 13'h008), 32'd2, 32'd1, 32'h100, 1'b1);
    br("bltu", btype(3'b110, 13'h1FF8), 32'hFFFF_FFFF, 32'd1, 32'h104, 1'b0);
    br("f3_010", btype(3'b010, 13'h008), 32'd3, 32'd3, 32'h108, 1'b0);
    br("bge", btype(3'b101, 13'h008), 32'd1, 32'hFFFF_FFFF, 32'h110, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_pc", pc, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    go();
    br("to_top", btype(3'b000, 13'h1FFC), 32'd0, 32'd0, 32'hFFFF_FFFC, 1'b1);
    br("wrap", 32'h0000_0013, 32'd0, 32'd1, 32'h0, 1'b0);
`ifdef BRANCH_SEQ_JAL_EN
    jal_pc = 32'h10;
    br("jal", 32'h0100_006F, 32'd0, 32'd0, jal_pc, 1'b1);
`else
    jal_pc = 32'h4;
    br("jal", 32'h0100_006F, 32'd0, 32'd0, jal_pc, 1'b0);
`endif
    rs1_val = 32'd7; rs2_val = 32'd7;
    exec(btype(3'b000, 13'h002), 0, cyc, bt, me);
    check("mis_err", {31'd0, me}, 1);
    check("mis_pc", pc, jal_pc);
    check("mis_busy", {31'd0, busy}, 0);
    check("mis_bt", {31'd0, bt}, 0);
    @(negedge clk);
    check("mis_pulse", {31'd0, misalign_err}, 0);
    go();
    rs1_val = 32'd1; rs2_val = 32'd2;
    exec(btype(3'b001, 13'h008), 4, cyc, bt, me);
    check("hold_pc", imem_addr, jal_pc + 32'd8);
    check("hold_bt", {31'd0, bt}, 1);
    run = 1'b0;
    exec(32'h0000_0013, 0, cyc, bt, me);
    check("stop_busy", {30'd0, busy, imem_req}, 0);
    check("stop_pc", pc, jal_pc + 32'd12);
    run = 1'b1;
    go();
    repeat (2) @(negedge clk);
    check("gnt_wait", {31'd0, imem_req}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", {31'd0, imem_req}, 0);
    check("arst_pc", pc, 32'h0);
    check("arst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle", {30'd0, busy, imem_req}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
